// File: rtl/sha256_digest_tx.sv
// Digest unload stage: snapshots the final SHA-256 state on load and streams it
// out as N_WORDS big-endian words (H0 first) over a valid/ready handshake.
module sha256_digest_tx #(
    parameter int WORD_W  = 32,
    parameter int N_WORDS = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        load,
    input  logic [WORD_W*N_WORDS-1:0]   digest_i,
    input  logic                        clr_ovf,
    output logic [WORD_W-1:0]           tx_data,
    output logic                        tx_valid,
    output logic                        tx_last,
    input  logic                        tx_ready,
    output logic                        busy,
    output logic                        overrun
);

    localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    // state | meaning
    // IDLE  | no digest held, outputs quiet
    // SEND  | digest held, presenting word[idx]
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]                 state_q;
    logic [WORD_W*N_WORDS-1:0]  buf_q;
    logic [IDX_W-1:0]           idx_q;
    logic                       ovf_q;
    logic [WORD_W-1:0]          word_sel;
    logic                       in_send;
    logic                       at_last;
    logic                       xfer;
    logic                       reload;
    logic                       drop;

    assign in_send = (state_q == SEND);
    assign at_last = (idx_q == IDX_W'(N_WORDS - 1));
    assign xfer    = in_send & tx_ready;
    // A load is only accepted when the buffer is free at the coming edge.
    assign reload  = load & (~in_send | (xfer & at_last));
    assign drop    = load & ~reload;

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                word_sel = buf_q[(N_WORDS-1-i)*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
        end else if (reload) begin
            state_q <= SEND;
            buf_q   <= digest_i;
            idx_q   <= '0;
        end else if (xfer) begin
            if (at_last) begin
                state_q <= IDLE;
                idx_q   <= '0;
            end else begin
                idx_q   <= idx_q + IDX_W'(1);
            end
        end
    end

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    assign tx_valid = in_send;
    assign busy     = in_send;
    assign tx_last  = in_send & at_last;
    assign tx_data  = in_send ? word_sel : '0;
    assign overrun  = ovf_q;

endmodule

// File: tb/tb_sha256_digest_tx.sv
// Scoreboard bench for sha256_digest_tx: a word-queue model predicts the stream,
// a negedge monitor compares every presented word and the status outputs.
module tb_sha256_digest_tx;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         load = 1'b0;
    logic [255:0] digest_i = '0;
    logic         clr_ovf = 1'b0;
    logic [31:0]  tx_data;
    logic         tx_valid;
    logic         tx_last;
    logic         tx_ready = 1'b0;
    logic         busy;
    logic         overrun;

    int n_checks = 0;
    int n_pass   = 0;

    logic [32:0] exp_q[$];
    int          rem = 0;
    logic        exp_ovf = 1'b0;

    localparam logic [255:0] ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] ONES = {8{32'h11111111}};

    sha256_digest_tx #(.WORD_W(32), .N_WORDS(8)) dut (
        .CLK(CLK), .RST(RST), .load(load), .digest_i(digest_i), .clr_ovf(clr_ovf),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .busy(busy), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a digest is a list of 8 words; a load is accepted only
    // when nothing remains to send, or the last remaining word leaves this edge.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            rem = 0;
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            bit moving, accept;
            moving = (rem > 0) && tx_ready;
            accept = load && (rem == 0 || (rem == 1 && moving));
            if (moving) rem--;
            if (accept) begin
                for (int i = 0; i < 8; i++)
                    exp_q.push_back({(i == 7), digest_i[255-32*i -: 32]});
                rem += 8;
            end
            if (load && !accept) exp_ovf = 1'b1;
            else if (clr_ovf) exp_ovf = 1'b0;
        end
    end

    // Monitor
    always @(negedge CLK) begin
        if (!RST) begin
            chk("tx_valid", 64'(tx_valid), 64'(rem > 0));
            chk("busy", 64'(busy), 64'(rem > 0));
            chk("overrun", 64'(overrun), 64'(exp_ovf));
            if (tx_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(tx_data), 64'hDEAD_BEEF_0000_0000);
                end else begin
                    chk("tx_data", 64'(tx_data), 64'(exp_q[0][31:0]));
                    chk("tx_last", 64'(tx_last), 64'(exp_q[0][32]));
                    if (tx_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("tx_last_idle", 64'(tx_last), 64'd0);
            end
        end
    end

    task automatic step(input logic ld, input logic [255:0] d, input logic rdy, input logic clr);
        load = ld; digest_i = d; tx_ready = rdy; clr_ovf = clr;
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [255:0] rd;
        #12;
        chk("rst_valid", 64'(tx_valid), 64'd0);
        chk("rst_data", 64'(tx_data), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        @(posedge CLK); #1;
        // load during reset must be ignored
        load = 1'b1; digest_i = ABC;
        @(posedge CLK); #3;
        RST = 1'b0; load = 1'b0;
        @(posedge CLK); #1;

        // Basic unload
        step(1, ABC, 1, 0);
        for (int i = 0; i < 10; i++) step(0, '0, 1, 0);

        // Backpressure 1,0,0 pattern
        step(1, ABC, 0, 0);
        for (int i = 0; i < 30; i++) step(0, '0, (i % 3) == 0, 0);

        // Back-to-back reload on the final transfer
        step(1, ABC, 1, 0);
        for (int i = 0; i < 7; i++) step(0, '0, 1, 0);
        step(1, ONES, 1, 0);
        for (int i = 0; i < 10; i++) step(0, '0, 1, 0);

        // Overrun on word 3, then clr together with a dropped load
        step(1, ABC, 1, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
        step(1, ONES, 1, 0);
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
        step(1, ABC, 0, 0);
        step(1, ONES, 0, 1);
        step(0, '0, 0, 0);
        chk("ovf_set_wins", 64'(overrun), 64'd1);
        for (int i = 0; i < 10; i++) step(0, '0, 1, 0);
        step(0, '0, 1, 1);
        step(0, '0, 1, 0);
        chk("ovf_cleared", 64'(overrun), 64'd0);

        // Reset mid-stream on word 5
        step(1, ABC, 1, 0);
        for (int i = 0; i < 5; i++) step(0, '0, 1, 0);
        #2 RST = 1'b1;
        #1;
        chk("amid_valid", 64'(tx_valid), 64'd0);
        chk("amid_busy", 64'(busy), 64'd0);
        chk("amid_last", 64'(tx_last), 64'd0);
        chk("amid_data", 64'(tx_data), 64'd0);
        @(posedge CLK); #3;
        RST = 1'b0;
        @(posedge CLK); #1;
        step(1, ONES, 1, 0);
        for (int i = 0; i < 10; i++) step(0, '0, 1, 0);

        // Idle hold
        for (int i = 0; i < 20; i++) step(0, '0, 1, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            for (int w = 0; w < 8; w++) rd[32*w +: 32] = $urandom;
            step(($urandom_range(0, 5) == 0), rd, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
        end
        for (int i = 0; i < 40; i++) step(0, '0, 1, 0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
